fb_pixel_writer: RTL

Parametrised framebuffer pixel writer that sits between the line rasteriser and the framebuffer memory port. It converts rasteriser (x, y, steep) coordinates into a linear framebuffer address and passes through a per-pixel colour. It clips off-screen pixels and counts them. It also provides a full-screen clear mode that sweeps every address with a fill colour. Input and output both use valid/ready handshakes, with a 2-stage pipeline between them.

---
 rtl/fb_pixel_writer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: maps rasteriser coordinates to linear addresses,
// clips off-screen pixels and provides a full-frame clear sweep.
module fb_pixel_writer #(
    parameter int COORD_W = 10,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int COL_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               steep,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    input  logic [COL_W-1:0]   color_in,
    input  logic               clear_req,
    input  logic [COL_W-1:0]   clear_color,
    output logic               clear_busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  FB_addr,
    output logic [COL_W-1:0]   color_out,
    output logic [15:0]        clip_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [ADDR_W-1:0] H_MULT    = ADDR_W'(H_RES);

    state_t               r_state;
    state_t               w_nextState;

    logic                 r_s1Valid;
    logic [COORD_W-1:0]   r_s1Col;
    logic [COORD_W-1:0]   r_s1Row;
    logic [COL_W-1:0]     r_s1Color;

    logic                 r_outValid;
    logic [ADDR_W-1:0]    r_addr;
    logic [COL_W-1:0]     r_color;

    logic [COL_W-1:0]     r_fillColor;
    logic [ADDR_W-1:0]    r_cnt;
    logic [15:0]          r_clipCnt;

    logic                 w_advance;
    logic                 w_inHs;
    logic                 w_clip;
    logic [COORD_W-1:0]   w_col;
    logic [COORD_W-1:0]   w_row;
    logic [ADDR_W-1:0]    w_pixAddr;

    assign w_advance = !r_outValid || out_ready;
    assign in_ready  = (r_state == IDLE) && w_advance;
    assign w_inHs    = in_valid && in_ready;

    assign w_col  = steep ? y_coord : x_coord;
    assign w_row  = steep ? x_coord : y_coord;
    assign w_clip = (32'(w_col) >= 32'(H_RES)) || (32'(w_row) >= 32'(V_RES));

    // H_RES is a constant, so this multiply reduces to shifts and adds
    assign w_pixAddr = ADDR_W'(r_s1Row) * H_MULT + ADDR_W'(r_s1Col);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (clear_req) w_nextState = DRAIN;
            DRAIN:   if (!r_s1Valid) w_nextState = CLEAR;
            CLEAR:   if (w_advance && (r_cnt == LAST_ADDR)) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_fillColor <= '0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == IDLE) && clear_req) begin
                r_fillColor <= clear_color;
            end
            if (r_state == DRAIN) begin
                r_cnt <= '0;
            end else if ((r_state == CLEAR) && w_advance) begin
                r_cnt <= (r_cnt == LAST_ADDR) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // Clipped pixels leave S1 empty, so they never occupy a pipeline slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Col   <= '0;
            r_s1Row   <= '0;
            r_s1Color <= '0;
        end else if (w_advance) begin
            r_s1Valid <= w_inHs && !w_clip;
            if (w_inHs && !w_clip) begin
                r_s1Col   <= w_col;
                r_s1Row   <= w_row;
                r_s1Color <= color_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_addr     <= '0;
            r_color    <= '0;
        end else if (w_advance) begin
            if (r_state == CLEAR) begin
                r_outValid <= 1'b1;
                r_addr     <= r_cnt;
                r_color    <= r_fillColor;
            end else begin
                r_outValid <= r_s1Valid;
                if (r_s1Valid) begin
                    r_addr  <= w_pixAddr;
                    r_color <= r_s1Color;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clipCnt <= '0;
        end else if (w_inHs && w_clip && (r_clipCnt != 16'hFFFF)) begin
            r_clipCnt <= r_clipCnt + 16'd1;
        end
    end

    assign clear_busy = (r_state != IDLE);
    assign out_valid  = r_outValid;
    assign FB_addr    = r_addr;
    assign color_out  = r_color;
    assign clip_cnt   = r_clipCnt;

endmodule
